// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core (port C) and the
// debug/loader port (D); one access in flight, reads hold the memory until data returns.
module dmem_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ready,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned AWX = AW + 1;
  localparam int unsigned CW  = 3;
  localparam logic [AWX-1:0] ADDR_LIMIT = AWX'(DEPTH_WORDS * 4);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_RWAIT = 1'b1
  } state_e;

  state_e          state_q;
  logic            last_g_q;   // 0 = C, 1 = D
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   raddr_q;
  logic            owner_q;
  logic            c_rvalid_q;
  logic            d_rvalid_q;
  logic            c_err_q;
  logic            d_err_q;
  logic [DW-1:0]   c_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic            idle;
  logic            rwait;
  logic            gnt_c;
  logic            gnt_d;
  logic            gnt_any;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_legal;
  logic            do_wr;
  logic            do_rd;

  assign idle  = (state_q == ST_IDLE) && !rst;
  assign rwait = (state_q == ST_RWAIT) && !rst;

  // Grant: single requester wins; on a tie the port that did not win last time.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (idle) begin
      if (c_req && d_req) begin
        gnt_c = last_g_q;
        gnt_d = !last_g_q;
      end else begin
        gnt_c = c_req;
        gnt_d = d_req;
      end
    end
  end

  assign gnt_any   = gnt_c || gnt_d;
  assign sel_we    = gnt_d ? d_we    : c_we;
  assign sel_addr  = gnt_d ? d_addr  : c_addr;
  assign sel_wdata = gnt_d ? d_wdata : c_wdata;
  assign sel_legal = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < ADDR_LIMIT);
  assign do_wr     = gnt_any && sel_we && sel_legal;
  assign do_rd     = gnt_any && !sel_we && sel_legal;

  // Memory interface is driven only by an accepted legal access or a read in flight.
  always_comb begin
    mem_wr    = do_wr;
    mem_rd    = do_rd || rwait;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rwait) begin
      mem_addr = raddr_q;
    end else if (do_rd || do_wr) begin
      mem_addr = sel_addr;
    end
    if (do_wr) begin
      mem_wdata = sel_wdata;
    end
  end

  assign c_ready  = gnt_c;
  assign d_ready  = gnt_d;
  assign busy     = (state_q == ST_RWAIT);
  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_err    = c_err_q;
  assign d_err    = d_err_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_g_q   <= 1'b1;
      cnt_q      <= '0;
      raddr_q    <= '0;
      owner_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (gnt_any) begin
          last_g_q <= gnt_d;
          if (!sel_legal) begin
            // Rejected access: error pulse, and a zero result for a load.
            if (gnt_d) begin
              d_err_q <= 1'b1;
              if (!sel_we) begin
                d_rvalid_q <= 1'b1;
                d_rdata_q  <= '0;
              end
            end else begin
              c_err_q <= 1'b1;
              if (!sel_we) begin
                c_rvalid_q <= 1'b1;
                c_rdata_q  <= '0;
              end
            end
          end else if (!sel_we) begin
            raddr_q <= sel_addr;
            owner_q <= gnt_d;
            cnt_q   <= CW'(RD_LAT);
            state_q <= ST_RWAIT;
          end
        end
      end else begin
        cnt_q <= cnt_q - CW'(1);
        // Last wait cycle: memory data is valid now.
        if (cnt_q == CW'(1)) begin
          state_q <= ST_IDLE;
          if (owner_q) begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= mem_rdata;
          end else begin
            c_rvalid_q <= 1'b1;
            c_rdata_q  <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 3), each with its own
// memory, checked every cycle against a cycle-scheduled access model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT0  = 1;
  localparam int unsigned LAT1  = 3;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rq_t c0, d0, c1, d1;

  logic [1:0]  c_ready, c_rvalid, c_err, d_ready, d_rvalid, d_err;
  logic [1:0]  mem_rd, mem_wr, busy;
  logic [31:0] c_rdata   [2];
  logic [31:0] d_rdata   [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  dmem_arbiter #(.AW(32), .DW(32), .DEPTH_WORDS(DEPTH), .RD_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .c_req(c0.req), .c_we(c0.we), .c_addr(c0.addr), .c_wdata(c0.wdata),
    .c_ready(c_ready[0]), .c_rvalid(c_rvalid[0]), .c_rdata(c_rdata[0]), .c_err(c_err[0]),
    .d_req(d0.req), .d_we(d0.we), .d_addr(d0.addr), .d_wdata(d0.wdata),
    .d_ready(d_ready[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  dmem_arbiter #(.AW(32), .DW(32), .DEPTH_WORDS(DEPTH), .RD_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .c_req(c1.req), .c_we(c1.we), .c_addr(c1.addr), .c_wdata(c1.wdata),
    .c_ready(c_ready[1]), .c_rvalid(c_rvalid[1]), .c_rdata(c_rdata[1]), .c_err(c_err[1]),
    .d_req(d1.req), .d_we(d1.we), .d_addr(d1.addr), .d_wdata(d1.wdata),
    .d_ready(d_ready[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Data memories: synchronous write, read data delayed through a latency pipe.
  logic [31:0] mem [2][DEPTH];
  logic [31:0] rp  [2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_wr[k]) mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
      rp[k][0] <= mem[k][mem_addr[k][9:2]];
      for (int i = 1; i < 4; i++) rp[k][i] <= rp[k][i-1];
    end
  end
  assign mem_rdata[0] = rp[0][LAT0-1];
  assign mem_rdata[1] = rp[1][LAT1-1];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) mem[k][i] <= 32'hA000_0000 + 32'(i);
  end

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[dut%0d] cyc=%0d got=%h exp=%h", name, k, cyc, act, exp);
    end
  endtask

  // Model state: shadow memory plus a schedule of when the memory is held and
  // when the single outstanding result is due.
  logic [31:0] shadow [2][DEPTH];
  int          rd_until  [2];
  logic [31:0] rd_addr   [2];
  int          pend_cyc  [2];
  logic        pend_d    [2];
  logic        pend_err  [2];
  logic        pend_rv   [2];
  logic [31:0] pend_data [2];
  logic        last_d    [2];
  logic [31:0] exp_rc    [2];
  logic [31:0] exp_rd    [2];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) shadow[k][i] = 32'hA000_0000 + 32'(i);
  end

  task automatic model_step(input int k);
    rq_t c, d, r;
    int lat;
    logic gd;
    logic e_cr, e_dr, e_crv, e_drv, e_cer, e_der, e_mrd, e_mwr, e_busy;
    logic [31:0] e_ma, e_mwd;
    c = (k == 0) ? c0 : c1;
    d = (k == 0) ? d0 : d1;
    lat = (k == 0) ? int'(LAT0) : int'(LAT1);
    {e_cr, e_dr, e_crv, e_drv, e_cer, e_der, e_mrd, e_mwr, e_busy} = '0;
    e_ma = '0;
    e_mwd = '0;
    if (rst) begin
      rd_until[k] = -1;
      pend_cyc[k] = -1;
      last_d[k]   = 1'b1;
      exp_rc[k]   = '0;
      exp_rd[k]   = '0;
    end else begin
      e_busy = (cyc <= rd_until[k]);
      if (pend_cyc[k] == cyc) begin
        if (pend_d[k]) begin
          e_drv = pend_rv[k]; e_der = pend_err[k];
          if (pend_rv[k]) exp_rd[k] = pend_data[k];
        end else begin
          e_crv = pend_rv[k]; e_cer = pend_err[k];
          if (pend_rv[k]) exp_rc[k] = pend_data[k];
        end
        pend_cyc[k] = -1;
      end
      if (e_busy) begin
        e_mrd = 1'b1;
        e_ma  = rd_addr[k];
      end else if (c.req || d.req) begin
        gd = (c.req && d.req) ? !last_d[k] : d.req;
        r  = gd ? d : c;
        if (gd) e_dr = 1'b1; else e_cr = 1'b1;
        last_d[k] = gd;
        pend_d[k] = gd;
        if (r.addr[1:0] != 2'b00 || r.addr >= DEPTH * 4) begin
          pend_cyc[k] = cyc + 1; pend_err[k] = 1'b1; pend_rv[k] = !r.we; pend_data[k] = '0;
        end else if (r.we) begin
          e_mwr = 1'b1; e_ma = r.addr; e_mwd = r.wdata;
          shadow[k][r.addr[9:2]] = r.wdata;
        end else begin
          e_mrd = 1'b1; e_ma = r.addr;
          rd_until[k] = cyc + lat; rd_addr[k] = r.addr;
          pend_cyc[k] = cyc + lat + 1; pend_err[k] = 1'b0; pend_rv[k] = 1'b1;
          pend_data[k] = shadow[k][r.addr[9:2]];
        end
      end
    end
    chk("c_ready",   k, 32'(c_ready[k]),  32'(e_cr));
    chk("d_ready",   k, 32'(d_ready[k]),  32'(e_dr));
    chk("c_rvalid",  k, 32'(c_rvalid[k]), 32'(e_crv));
    chk("d_rvalid",  k, 32'(d_rvalid[k]), 32'(e_drv));
    chk("c_err",     k, 32'(c_err[k]),    32'(e_cer));
    chk("d_err",     k, 32'(d_err[k]),    32'(e_der));
    chk("mem_rd",    k, 32'(mem_rd[k]),   32'(e_mrd));
    chk("mem_wr",    k, 32'(mem_wr[k]),   32'(e_mwr));
    chk("busy",      k, 32'(busy[k]),     32'(e_busy));
    chk("mem_addr",  k, mem_addr[k],      e_ma);
    chk("mem_wdata", k, mem_wdata[k],     e_mwd);
    chk("c_rdata",   k, c_rdata[k],       exp_rc[k]);
    chk("d_rdata",   k, d_rdata[k],       exp_rd[k]);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  function automatic rq_t mk(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
    rq_t r;
    r.req = req; r.we = we; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr + 1);
    $fatal(1);
  end

  initial begin
    c0 = '0; d0 = '0; c1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Store then load on C, latency 1.
    c0 = mk(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_wr_ready", 0, 32'(c_ready[0]), 32'd1);
    chk("t1_mem_wr", 0, 32'(mem_wr[0]), 32'd1);
    chk("t1_mem_addr", 0, mem_addr[0], 32'h10);
    nxt(); c0 = mk(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("t1_rd_ready", 0, 32'(c_ready[0]), 32'd1);
    nxt(); c0 = '0;
    @(negedge clk);
    chk("t1_busy", 0, 32'(busy[0]), 32'd1);
    nxt();
    @(negedge clk);
    chk("t1_rvalid", 0, 32'(c_rvalid[0]), 32'd1);
    chk("t1_rdata", 0, c_rdata[0], 32'hDEAD_BEEF);

    // Reset, then simultaneous loads: C first, D two cycles later.
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    c0 = mk(1'b1, 1'b0, 32'h10, 32'h0);
    d0 = mk(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("t2_c_first", 0, 32'(c_ready[0]), 32'd1);
    chk("t2_d_wait", 0, 32'(d_ready[0]), 32'd0);
    nxt(); c0 = '0;
    @(negedge clk);
    chk("t2_d_wait2", 0, 32'(d_ready[0]), 32'd0);
    nxt();
    @(negedge clk);
    chk("t2_d_ready", 0, 32'(d_ready[0]), 32'd1);
    chk("t2_c_rdata", 0, c_rdata[0], 32'hDEAD_BEEF);
    nxt(); d0 = '0;
    nxt();
    @(negedge clk);
    chk("t2_d_rvalid", 0, 32'(d_rvalid[0]), 32'd1);
    chk("t2_d_rdata", 0, d_rdata[0], 32'hA000_0008);
    chk("t2_c_keep", 0, c_rdata[0], 32'hDEAD_BEEF);

    // Continuous stores from both ports alternate every cycle.
    nxt();
    c0 = mk(1'b1, 1'b1, 32'h40, 32'h1111_1111);
    d0 = mk(1'b1, 1'b1, 32'h44, 32'h2222_2222);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_c_alt", 0, 32'(c_ready[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_d_alt", 0, 32'(d_ready[0]), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_wr", 0, 32'(mem_wr[0]), 32'd1);
      nxt();
    end

    // Misaligned store on C, out-of-range load on D.
    c0 = mk(1'b1, 1'b1, 32'h6, 32'h55);
    d0 = '0;
    @(negedge clk);
    chk("t4_c_ready", 0, 32'(c_ready[0]), 32'd1);
    chk("t4_no_wr", 0, 32'(mem_wr[0]), 32'd0);
    nxt(); c0 = '0; d0 = mk(1'b1, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    chk("t4_c_err", 0, 32'(c_err[0]), 32'd1);
    chk("t4_d_ready", 0, 32'(d_ready[0]), 32'd1);
    chk("t4_no_rd", 0, 32'(mem_rd[0]), 32'd0);
    nxt(); d0 = '0;
    @(negedge clk);
    chk("t4_d_err", 0, 32'(d_err[0]), 32'd1);
    chk("t4_d_rvalid", 0, 32'(d_rvalid[0]), 32'd1);
    chk("t4_d_rdata", 0, d_rdata[0], 32'h0);

    // Reset in the middle of a read.
    nxt(); c0 = mk(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    chk("t5_ready", 0, 32'(c_ready[0]), 32'd1);
    nxt(); c0 = '0;
    @(negedge clk);
    chk("t5_busy", 0, 32'(busy[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rd_clr", 0, 32'(mem_rd[0]), 32'd0);
    chk("t5_busy_clr", 0, 32'(busy[0]), 32'd0);
    nxt();
    nxt(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rvalid", 0, 32'(c_rvalid[0]), 32'd0);
      nxt();
    end
    c0 = mk(1'b1, 1'b0, 32'h40, 32'h0);
    d0 = mk(1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    chk("t5_c_wins", 0, 32'(c_ready[0]), 32'd1);
    chk("t5_d_loses", 0, 32'(d_ready[0]), 32'd0);
    nxt(); c0 = '0;
    nxt();
    @(negedge clk);
    chk("t5_c_rdata", 0, c_rdata[0], 32'h1111_1111);
    nxt(); d0 = '0;
    nxt();
    @(negedge clk);
    chk("t5_d_rdata", 0, d_rdata[0], 32'h2222_2222);

    // Latency 3: C load holds the memory, D waits.
    nxt(); c1 = mk(1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    chk("t6_c_ready", 1, 32'(c_ready[1]), 32'd1);
    nxt(); c1 = '0; d1 = mk(1'b1, 1'b0, 32'hC, 32'h0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk("t6_busy", 1, 32'(busy[1]), 32'd1);
      chk("t6_d_blocked", 1, 32'(d_ready[1]), 32'd0);
      nxt();
    end
    @(negedge clk);
    chk("t6_d_ready", 1, 32'(d_ready[1]), 32'd1);
    chk("t6_c_rvalid", 1, 32'(c_rvalid[1]), 32'd1);
    chk("t6_c_rdata", 1, c_rdata[1], 32'hA000_0002);
    nxt(); d1 = '0;
    repeat (3) nxt();
    @(negedge clk);
    chk("t6_d_rvalid", 1, 32'(d_rvalid[1]), 32'd1);
    chk("t6_d_rdata", 1, d_rdata[1], 32'hA000_0003);

    repeat (3) nxt();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
